// File: rtl/pixel_mem_pkg.sv
// Pixel counter memory controller: shared types and constants.
// Widths, saturation limit, FSM states and default SRAM timing.
package pixel_mem_pkg;

  localparam int ADDR_BITS = 6;
  localparam int DATA_BITS = 12;

  localparam logic [DATA_BITS-1:0] CNT_MAX = 12'hFFF;

  localparam int PULSE_CYC_DEF   = 2;
  localparam int PRECH_CYC_DEF   = 2;
  localparam int TIMEOUT_CYC_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    READ,
    PRE_R,
    WRITE,
    PRE_W
  } state_t;

  typedef enum logic {
    PORT_INC = 1'b0,
    PORT_RDO = 1'b1
  } port_t;

  function automatic logic [DATA_BITS-1:0] sat_inc(
    input logic [DATA_BITS-1:0] v
  );
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pixel_mem_ctrl_rr_arb2.sv
// Two-way round-robin arbiter for the pixel memory controller.
// Port 0 has priority after reset; the last winner yields next time.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic ptr;

  // Pick port 0 unless port 1 holds priority and is requesting.
  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!ptr || !req[1])) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

  // Hand priority to the port that did not win the accepted grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (en && |gnt) begin
      ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/pixel_mem_ctrl.sv
// Pixel counter SRAM controller: read-modify-write increment and
// readout with optional clear, strobe-timed asynchronous SRAM.
module pixel_mem_ctrl
  import pixel_mem_pkg::*;
#(
  parameter int PULSE_CYC   = PULSE_CYC_DEF,
  parameter int PRECH_CYC   = PRECH_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc_req,
  input  logic [ADDR_BITS-1:0] inc_addr,
  output logic                 inc_ack,
  input  logic                 rdo_req,
  input  logic [ADDR_BITS-1:0] rdo_addr,
  input  logic                 rdo_clr,
  output logic                 rdo_ack,
  output logic [DATA_BITS-1:0] rdo_data,
  output logic                 busy,
  output logic                 err,
  output logic                 sram_read,
  output logic                 sram_write,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [DATA_BITS-1:0] sram_din,
  input  logic [DATA_BITS-1:0] sram_dout,
  input  logic                 sram_read_done,
  input  logic                 sram_write_done
);

  localparam int MAX_A =
    (PULSE_CYC > PRECH_CYC) ? PULSE_CYC : PRECH_CYC;
  localparam int MAX_C =
    (TIMEOUT_CYC > MAX_A) ? TIMEOUT_CYC : MAX_A;
  localparam int CW = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] PRECH_LAST = CW'(PRECH_CYC - 1);
  localparam logic [CW-1:0] TOUT_LAST  = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] PRECH_INIT = CW'(PRECH_CYC);

  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;

  port_t port_q, port_nx;
  logic  clr_q, clr_nx;

  logic [DATA_BITS-1:0] cap, cap_nx;
  logic [DATA_BITS-1:0] din_nx, data_nx;
  logic [ADDR_BITS-1:0] addr_nx;

  logic err_nx, rd_nx, wr_nx, busy_nx;
  logic inc_ack_nx, rdo_ack_nx, fin;

  logic [1:0] gnt;
  logic       arb_en;

  logic need_wr, done_in, hit, tout, pulse_end;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({rdo_req, inc_req}),
    .en    (arb_en),
    .gnt   (gnt)
  );

  // Strobe completion: minimum width met and done seen, or timeout.
  always_comb begin
    need_wr   = (port_q == PORT_INC) || clr_q;
    done_in   = (state == WRITE) ? sram_write_done
                                 : sram_read_done;
    hit       = (cnt >= PULSE_LAST) && done_in;
    tout      = !hit && (cnt >= TOUT_LAST);
    pulse_end = hit || tout;
  end

  // Next state, counter and registered output values.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    port_nx  = port_q;
    clr_nx   = clr_q;
    addr_nx  = sram_addr;
    cap_nx   = cap;
    din_nx   = sram_din;
    data_nx  = rdo_data;
    err_nx   = err;
    arb_en   = 1'b0;

    unique case (state)
      IDLE: begin
        if (cnt != '0) begin
          cnt_nx = cnt - 1'b1;
        end else if (|gnt) begin
          arb_en   = 1'b1;
          state_nx = SETUP;
          port_nx  = gnt[1] ? PORT_RDO : PORT_INC;
          clr_nx   = rdo_clr;
          addr_nx  = gnt[1] ? rdo_addr : inc_addr;
        end
      end
      SETUP: begin
        state_nx = READ;
        cnt_nx   = '0;
      end
      READ: begin
        if (pulse_end) begin
          state_nx = PRE_R;
          cnt_nx   = '0;
          cap_nx   = sram_dout;
          if (need_wr) begin
            din_nx = (port_q == PORT_INC)
                   ? sat_inc(sram_dout) : '0;
          end
          if (tout) err_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      PRE_R: begin
        if (cnt == PRECH_LAST) begin
          state_nx = need_wr ? WRITE : IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      WRITE: begin
        if (pulse_end) begin
          state_nx = PRE_W;
          cnt_nx   = '0;
          if (tout) err_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      PRE_W: begin
        if (cnt == PRECH_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase

    rd_nx   = (state_nx == READ);
    wr_nx   = (state_nx == WRITE);
    busy_nx = (state_nx != IDLE);

    fin = ((state_nx == PRE_W) ||
           ((state_nx == PRE_R) && !need_wr)) &&
          (cnt_nx == PRECH_LAST);

    inc_ack_nx = fin && (port_q == PORT_INC);
    rdo_ack_nx = fin && (port_q == PORT_RDO);
    if (rdo_ack_nx) data_nx = cap_nx;
  end

  // State, counter, latched request and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= PRECH_INIT;
      port_q     <= PORT_INC;
      clr_q      <= 1'b0;
      cap        <= '0;
      sram_addr  <= '0;
      sram_din   <= '0;
      rdo_data   <= '0;
      err        <= 1'b0;
      sram_read  <= 1'b0;
      sram_write <= 1'b0;
      busy       <= 1'b0;
      inc_ack    <= 1'b0;
      rdo_ack    <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      port_q     <= port_nx;
      clr_q      <= clr_nx;
      cap        <= cap_nx;
      sram_addr  <= addr_nx;
      sram_din   <= din_nx;
      rdo_data   <= data_nx;
      err        <= err_nx;
      sram_read  <= rd_nx;
      sram_write <= wr_nx;
      busy       <= busy_nx;
      inc_ack    <= inc_ack_nx;
      rdo_ack    <= rdo_ack_nx;
    end
  end

endmodule

// File: tb/tb_pixel_mem_ctrl.sv
// Directed bench for pixel_mem_ctrl with a behavioural SRAM model.
// Checks data, latency, arbitration, strobe timing, timeout, reset.
module tb_pixel_mem_ctrl;

  localparam int PULSE_CYC   = 2;
  localparam int PRECH_CYC   = 2;
  localparam int TIMEOUT_CYC = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inc_req;
  logic [5:0]  inc_addr;
  logic        inc_ack;
  logic        rdo_req;
  logic [5:0]  rdo_addr;
  logic        rdo_clr;
  logic        rdo_ack;
  logic [11:0] rdo_data;
  logic        busy;
  logic        err;
  logic        sram_read;
  logic        sram_write;
  logic [5:0]  sram_addr;
  logic [11:0] sram_din;
  logic [11:0] sram_dout;
  logic        sram_read_done;
  logic        sram_write_done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #2 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pixel_mem_ctrl #(
    .PULSE_CYC   (PULSE_CYC),
    .PRECH_CYC   (PRECH_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .inc_req         (inc_req),
    .inc_addr        (inc_addr),
    .inc_ack         (inc_ack),
    .rdo_req         (rdo_req),
    .rdo_addr        (rdo_addr),
    .rdo_clr         (rdo_clr),
    .rdo_ack         (rdo_ack),
    .rdo_data        (rdo_data),
    .busy            (busy),
    .err             (err),
    .sram_read       (sram_read),
    .sram_write      (sram_write),
    .sram_addr       (sram_addr),
    .sram_din        (sram_din),
    .sram_dout       (sram_dout),
    .sram_read_done  (sram_read_done),
    .sram_write_done (sram_write_done)
  );

  // SRAM behavioural model
  bit [11:0]  mem [64];
  int         rd_cnt = 0;
  int         wr_cnt = 0;
  logic       pl_en;
  logic [5:0] pl_a;
  logic [11:0] pl_d;
  logic       wd_kill;

  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    if (sram_write) mem[sram_addr] <= sram_din;
    rd_cnt <= sram_read ? rd_cnt + 1 : 0;
    wr_cnt <= sram_write ? wr_cnt + 1 : 0;
  end

  assign sram_dout = mem[sram_addr];
  assign sram_read_done =
    sram_read && (rd_cnt >= PULSE_CYC - 1);
  assign sram_write_done =
    !wd_kill && sram_write && (wr_cnt >= PULSE_CYC - 1);

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // SRAM protocol monitor
  int   rd_len = 0;
  int   wr_len = 0;
  int   gap = 100;
  int   last_wr_len = 0;
  logic prev_rd = 1'b0;
  logic prev_wr = 1'b0;
  logic [5:0] prev_addr = '0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      rd_len  = 0;
      wr_len  = 0;
      gap     = 100;
      prev_rd = 1'b0;
      prev_wr = 1'b0;
    end else begin
      if (sram_read || sram_write)
        chk("strobe_excl", sram_read & sram_write, 0);
      if ((sram_read && !prev_rd) ||
          (sram_write && !prev_wr))
        chk("prech_gap", gap >= PRECH_CYC, 1);
      if ((sram_read && prev_rd) ||
          (sram_write && prev_wr))
        chk("addr_hold", sram_addr, prev_addr);
      if (prev_rd && !sram_read)
        chk("rd_pulse", rd_len >= PULSE_CYC, 1);
      if (prev_wr && !sram_write) begin
        chk("wr_pulse", wr_len >= PULSE_CYC, 1);
        last_wr_len = wr_len;
      end
      rd_len    = sram_read ? rd_len + 1 : 0;
      wr_len    = sram_write ? wr_len + 1 : 0;
      gap       = (sram_read || sram_write) ? 0 : gap + 1;
      prev_rd   = sram_read;
      prev_wr   = sram_write;
      prev_addr = sram_addr;
    end
  end

  task automatic preload(input logic [5:0] a,
                         input logic [11:0] d);
    pl_a  = a;
    pl_d  = d;
    pl_en = 1'b1;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic wait_ack(input bit rdo, input int lim,
                          output bit ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (rdo ? rdo_ack : inc_ack) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_any(input int lim,
                          output bit ok, output int which);
    ok = 1'b0;
    which = -1;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (inc_ack || rdo_ack) begin
        ok = 1'b1;
        which = rdo_ack ? 1 : 0;
        break;
      end
    end
  endtask

  task automatic readout(input logic [5:0] a,
                         input logic clr,
                         input int lat,
                         input logic [11:0] exp,
                         input string tag);
    bit ok;
    int at;
    int t0;
    rdo_addr = a;
    rdo_clr  = clr;
    rdo_req  = 1'b1;
    t0 = cyc;
    wait_ack(1'b1, 40, ok, at);
    rdo_req = 1'b0;
    chk({tag, "_to"}, ok, 1);
    chk({tag, "_lat"}, at - t0, lat);
    chk({tag, "_data"}, rdo_data, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    bit got;
    bit seen;
    int at;
    int prev;
    int t0;
    int which;
    int n;

    rst_n    = 1'b0;
    inc_req  = 1'b0;
    inc_addr = '0;
    rdo_req  = 1'b0;
    rdo_addr = '0;
    rdo_clr  = 1'b0;
    pl_en    = 1'b0;
    pl_a     = '0;
    pl_d     = '0;
    wd_kill  = 1'b0;
    prev     = 0;

    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_rd", sram_read, 0);
    chk("rst_wr", sram_write, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_din", sram_din, 0);
    chk("rst_data", rdo_data, 0);
    chk("rst_iack", inc_ack, 0);
    chk("rst_rack", rdo_ack, 0);

    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();

    // five back-to-back increments of address 3
    inc_addr = 6'd3;
    inc_req  = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 5; k++) begin
      wait_ack(1'b0, 40, ok, at);
      chk("inc_to", ok, 1);
      if (k == 0) chk("inc_lat", at - t0, 9);
      else chk("inc_spacing", at - prev, 10);
      prev = at;
    end
    inc_req = 1'b0;
    tick();
    tick();
    chk("mem3", mem[3], 5);
    readout(6'd3, 1'b0, 5, 12'd5, "rd3");
    tick();
    chk("idle_after_rd", busy, 0);

    // saturation at 12'hFFF
    preload(6'd10, 12'hFFE);
    chk("data_hold", rdo_data, 12'd5);
    inc_addr = 6'd10;
    inc_req  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_ack(1'b0, 40, ok, at);
      chk("sat_to", ok, 1);
    end
    inc_req = 1'b0;
    tick();
    tick();
    chk("mem10", mem[10], 12'hFFF);
    readout(6'd10, 1'b0, 5, 12'hFFF, "rd10");

    // readout with clear, then plain readout
    preload(6'd7, 12'd9);
    readout(6'd7, 1'b1, 9, 12'd9, "clr7");
    repeat (3) tick();
    chk("clr_hold", rdo_data, 12'd9);
    chk("mem7", mem[7], 0);
    readout(6'd7, 1'b0, 5, 12'd0, "rd7");

    // both ports held: alternating grants
    inc_addr = 6'd20;
    rdo_addr = 6'd20;
    rdo_clr  = 1'b0;
    inc_req  = 1'b1;
    rdo_req  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_any(40, ok, which);
      chk("arb_to", ok, 1);
      chk("arb_order", which, k % 2);
      if (which == 1)
        chk("arb_data", rdo_data, (k + 1) / 2);
    end
    inc_req = 1'b0;
    rdo_req = 1'b0;
    tick();
    tick();
    chk("mem20", mem[20], 2);

    // write done never arrives
    chk("err_pre", err, 0);
    wd_kill  = 1'b1;
    inc_addr = 6'd30;
    inc_req  = 1'b1;
    t0 = cyc;
    wait_ack(1'b0, 60, ok, at);
    inc_req = 1'b0;
    chk("tout_ack", ok, 1);
    chk("tout_lat", at - t0, 23);
    chk("tout_err", err, 1);
    chk("tout_len", last_wr_len, TIMEOUT_CYC);
    wd_kill = 1'b0;
    repeat (3) tick();
    chk("err_sticky", err, 1);

    // reset in the middle of a write
    inc_addr = 6'd40;
    inc_req  = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (sram_write) begin
        got = 1'b1;
        break;
      end
    end
    chk("wr_seen", got, 1);
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    chk("abort_wr", sram_write, 0);
    chk("abort_rd", sram_read, 0);
    chk("abort_ack", inc_ack, 0);
    chk("abort_busy", busy, 0);
    chk("abort_err", err, 0);
    chk("abort_addr", sram_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    got = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen = seen | inc_ack;
      if (busy) begin
        got = 1'b1;
        break;
      end
      n++;
    end
    chk("regrant_to", got, 1);
    chk("regrant_gap", n >= PRECH_CYC, 1);
    chk("no_abort_ack", seen, 0);
    wait_ack(1'b0, 40, ok, at);
    inc_req = 1'b0;
    chk("post_rst_ack", ok, 1);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pixel_mem_ctrl.md
PIXEL_MEM_CTRL -- requirements
Module: pixel_mem_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- PULSE_CYC, 2: minimum read/write pulse width in clk cycles (≥8 ns at 4 ns clk).
- PRECH_CYC, 2: minimum idle cycles between pulses.
- TIMEOUT_CYC, 16: cycles to wait for done before flagging an error.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- rst_n, in, 1: synchronous, active-low reset.
- inc_req, in, 1, increment request; held until inc_ack.
- inc_addr, in, 6, counter address; stable while inc_req.
- inc_ack, out, 1, one-cycle pulse when increment is written back.
- rdo_req, in, 1, readout request; held until rdo_ack.
- rdo_addr, in, 6, readout address; stable while rdo_req.
- rdo_clr, in, 1, clear location after readout; sampled at grant.
- rdo_ack, out, 1, one-cycle pulse; rdo_data valid this cycle.
- rdo_data, out, 12, readout value.
- busy, out, 1, high when state is not IDLE.
- err, out, 1, sticky timeout flag.
- sram_read, out, 1, SRAM read strobe.
- sram_write, out, 1, SRAM write strobe.
- sram_addr, out, 6, SRAM address.
- sram_din, out, 12, SRAM write data.
- sram_dout, in, 12, SRAM read data.
- sram_read_done, in, 1, SRAM read-complete flag.
- sram_write_done, in, 1, SRAM write-complete flag.
REQ-003 All outputs SHALL be driven from flops; no combinational path from any input to any sram_* output.

Function
REQ-004 The FSM SHALL have exactly the states IDLE, SETUP, READ, PRE_R, WRITE, PRE_W.
REQ-005 IDLE SHALL grant only when the precharge counter is zero and at least one request is high.
REQ-006 Arbitration SHALL be round-robin between the two ports; on simultaneous requests, the port not served last wins; after reset the inc port has priority.
REQ-007 At grant, the controller SHALL latch address, port and rdo_clr, then enter SETUP for 1 cycle with sram_addr valid and both strobes low.
REQ-008 READ SHALL hold sram_read high for at least PULSE_CYC cycles and until sram_read_done is sampled high; sram_dout SHALL be captured on the last READ cycle.
REQ-009 PRE_R and PRE_W SHALL hold both strobes low for PRECH_CYC cycles.
REQ-010 Write data SHALL be: for inc, captured data +1, saturating at 12'hFFF (no wrap to 0); for rdo with clr=1, 12'h000.
REQ-011 After PRE_R, the FSM SHALL go to WRITE for inc or rdo-with-clr, and otherwise to IDLE.
REQ-012 sram_din SHALL be stable from the cycle before WRITE through PRE_W.
REQ-013 WRITE SHALL follow the same rule as REQ-008, with sram_write and sram_write_done.
REQ-014 sram_addr SHALL be constant from SETUP through the final PRE state.
REQ-015 sram_read and sram_write SHALL never both be high.
REQ-016 The ack (inc_ack or rdo_ack) SHALL pulse on the last cycle of the final PRE state, and the FSM SHALL enter IDLE next; back-to-back requests SHALL then reach SETUP with no extra gap.
REQ-017 rdo_data SHALL hold the captured value from rdo_ack until the next rdo_ack.
REQ-018 If done is not seen within TIMEOUT_CYC cycles of a strobe rising, the controller SHALL set err, drop the strobe, and proceed as if done; the ack is still issued.
REQ-019 Minimum latency SHALL be: readout without clear, 1+PULSE_CYC+PRECH_CYC+1 cycles from grant to IDLE; increment, adds PULSE_CYC+PRECH_CYC.

Reset
REQ-020 When rst_n=0 at a clk edge, the controller SHALL set:
- state to IDLE;
- all strobes, acks and err to 0;
- sram_addr, sram_din and rdo_data to 0;
- the precharge counter to PRECH_CYC, so the first grant after reset is at least PRECH_CYC cycles after release;
- round-robin pointer to inc priority.
REQ-021 Reset mid-operation SHALL abort the operation without an ack; the SRAM content at an interrupted write address is undefined.

Structure
REQ-022 Package pixel_mem_pkg SHALL hold ADDR_BITS=6, DATA_BITS=12, CNT_MAX=12'hFFF, the state enum, and the default cycle counts.
REQ-023 A 2-way round-robin arbiter SHALL be a sub-module named rr_arb2; the remainder SHALL be a single FSM plus cycle counter.

Verification
REQ-024 The bench SHALL use the SRAM behavioural model with a 4 ns clk and SHALL fail on any RAM ERROR message. It SHALL cover these directed scenarios:
- 5 increments to addr 3 from 0, then readout addr 3 -> rdo_data=5, and exact cycle spacing per REQ-019.
- Preload addr 10=12'hFFE, 3 increments -> readout returns 12'hFFF.
- Readout addr 7 with clr=1 (value 9) -> rdo_data=9; a second readout -> 0.
- inc_req and rdo_req held together for 4 grants -> order inc, rdo, inc, rdo; no strobe overlap; precharge ≥ PRECH_CYC between pulses.
- sram_write_done forced to 0 -> err=1 after TIMEOUT_CYC, inc_ack still issued.
- rst_n low during WRITE -> strobes 0 next cycle, no ack, first new grant ≥ PRECH_CYC cycles after release.
